// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, latency
// counter width and word geometry.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W      = 3;
    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = WORD_W / 8;

endpackage

// File: rtl/dmem_array.sv
// Single-port word store with synchronous read and write; contents are never reset.
// rdata only changes on an enabled read, so it holds between responses.
module dmem_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for a CPU memory stage, with flush
// detection, word-aligned indexing and an out-of-range error flag.
//
// state | meaning
// IDLE  | capture the presented request on every edge
// WAIT  | count down latency; a changed request restarts the countdown
// RESP  | one-cycle mem_valid strobe, then back to IDLE
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] mem_addr,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] mem_write_data,
    output logic              mem_valid,
    output logic [WORD_W-1:0] mem_read_data,
    output logic              mem_err,
    output logic              busy
);

    localparam int                AW         = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LOAD   = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;
    localparam logic [WORD_W:0]   ADDR_LIMIT = (WORD_W + 1)'(WORD_BYTES * DEPTH_WORDS);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_write;
    logic              resp_zero;

    logic              changed;
    logic              capture;
    logic              enter_resp;
    logic [WORD_W-1:0] op_addr;
    logic [WORD_W-1:0] op_wdata;
    logic              op_write;
    logic              op_oor;
    logic              arr_en;
    logic [WORD_W-1:0] arr_rdata;

    // The access happens on the edge entering RESP; when that same edge also
    // captures (LATENCY=1), the live inputs are the request, not the registers.
    always_comb begin
        changed    = (mem_addr != req_addr) || (mem_write != req_write)
                     || (mem_write_data != req_wdata);
        capture    = (state == IDLE) || ((state == WAIT) && changed);
        enter_resp = capture ? (LATENCY == 1) : ((state == WAIT) && (cnt == '0));
        op_addr    = capture ? mem_addr       : req_addr;
        op_wdata   = capture ? mem_write_data : req_wdata;
        op_write   = capture ? mem_write      : req_write;
        op_oor     = ({1'b0, op_addr} >= ADDR_LIMIT);
        arr_en     = rst_n && enter_resp && !op_oor;
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (op_write),
        .addr  (op_addr[AW+1:2]),
        .wdata (op_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_write <= 1'b0;
            mem_valid <= 1'b0;
            mem_err   <= 1'b0;
            busy      <= 1'b0;
            resp_zero <= 1'b1;
        end else begin
            mem_valid <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                IDLE, WAIT: begin
                    if (capture) begin
                        req_addr  <= mem_addr;
                        req_wdata <= mem_write_data;
                        req_write <= mem_write;
                    end
                    if (enter_resp) begin
                        state     <= RESP;
                        busy      <= 1'b1;
                        mem_valid <= 1'b1;
                        mem_err   <= op_oor;
                        resp_zero <= op_write || op_oor;
                    end else if (capture) begin
                        state <= WAIT;
                        busy  <= 1'b1;
                        cnt   <= CNT_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Store and error responses read back as zero; otherwise the array's held read word.
    assign mem_read_data = resp_zero ? '0 : arr_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 2, 4) driven with
// directed and random requests, checked against a word-array reference model.
module tb_dmem_responder;

    localparam int NI    = 3;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n          [NI];
    logic [31:0] mem_addr       [NI];
    logic        mem_write      [NI];
    logic [31:0] mem_write_data [NI];
    logic        mem_valid      [NI];
    logic [31:0] mem_read_data  [NI];
    logic        mem_err        [NI];
    logic        busy           [NI];

    int n_checks = 0;
    int n_errs   = 0;

    logic [31:0] ref_mem [NI][DEPTH];
    bit          known   [NI][DEPTH];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
            dmem_responder #(
                .DEPTH_WORDS (DEPTH),
                .LATENCY     (L)
            ) u_dut (
                .clk            (clk),
                .rst_n          (rst_n[g]),
                .mem_addr       (mem_addr[g]),
                .mem_write      (mem_write[g]),
                .mem_write_data (mem_write_data[g]),
                .mem_valid      (mem_valid[g]),
                .mem_read_data  (mem_read_data[g]),
                .mem_err        (mem_err[g]),
                .busy           (busy[g])
            );
        end
    endgenerate

    function automatic int lat_of(int g);
        return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    endfunction

    function automatic bit is_oor(logic [31:0] a);
        return a >= 32'(4 * DEPTH);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while (busy[g] !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_eq("idle_timeout", 32'(busy[g]), 32'd0);
    endtask

    // Expected response for a completed request, then apply it to the model.
    task automatic score(input int g, input string tag, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input int got_lat, input logic er,
                         input logic [31:0] rd);
        bit o = is_oor(a);
        int idx = int'(a[11:2]);
        check_eq({tag, "_lat"}, 32'(got_lat), 32'(lat_of(g)));
        check_eq({tag, "_err"}, 32'(er), 32'(o));
        if (w || o) check_eq({tag, "_data"}, rd, 32'h0);
        else if (known[g][idx]) check_eq({tag, "_data"}, rd, ref_mem[g][idx]);
        if (w && !o) begin
            ref_mem[g][idx] = d;
            known[g][idx]   = 1'b1;
        end
    endtask

    task automatic run_txn(input int g, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input string tag);
        int got_lat = 0;
        logic [31:0] rd = '0;
        logic er = 1'b0;
        wait_idle(g);
        mem_addr[g] = a;
        mem_write[g] = w;
        mem_write_data[g] = d;
        for (int k = 1; k <= lat_of(g) + 3; k++) begin
            @(negedge clk);
            if (mem_valid[g] === 1'b1) begin
                got_lat = k;
                break;
            end
        end
        rd = mem_read_data[g];
        er = mem_err[g];
        mem_write[g] = 1'b0;
        score(g, tag, a, w, d, got_lat, er, rd);
    endtask

    // Start a store at a0, then redirect it to a1 one cycle later.
    task automatic run_abort(input int g, input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d, input string tag);
        int got_lat = 0;
        logic [31:0] rd = '0;
        logic er = 1'b0;
        wait_idle(g);
        mem_addr[g] = a0;
        mem_write[g] = 1'b1;
        mem_write_data[g] = d;
        @(negedge clk);
        check_eq({tag, "_early"}, 32'(mem_valid[g]), 32'd0);
        mem_addr[g] = a1;
        for (int k = 1; k <= lat_of(g) + 3; k++) begin
            @(negedge clk);
            if (mem_valid[g] === 1'b1) begin
                got_lat = k;
                break;
            end
        end
        rd = mem_read_data[g];
        er = mem_err[g];
        mem_write[g] = 1'b0;
        score(g, tag, a1, 1'b1, d, got_lat, er, rd);
    endtask

    bit prev_v0 = 1'b0;
    always @(negedge clk) begin
        if (mem_valid[0] === 1'b1) check_eq("l1_b2b", 32'(prev_v0), 32'd0);
        prev_v0 <= (mem_valid[0] === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic [31:0] a;
        logic        w;

        for (int g = 0; g < NI; g++) begin
            rst_n[g] = 1'b0;
            mem_addr[g] = '0;
            mem_write[g] = 1'b0;
            mem_write_data[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check_eq("rst_valid", 32'(mem_valid[g]), 32'd0);
            check_eq("rst_err",   32'(mem_err[g]),   32'd0);
            check_eq("rst_rdata", mem_read_data[g],  32'd0);
            check_eq("rst_busy",  32'(busy[g]),      32'd0);
            rst_n[g] = 1'b1;
        end

        // Store/load, misaligned load, out-of-range on LATENCY=2
        run_txn(1, 32'h10, 1'b1, 32'hDEADBEEF, "st_beef");
        run_txn(1, 32'h10, 1'b0, 32'h0, "ld_beef");
        run_txn(1, 32'h10, 1'b1, 32'h12345678, "st_1234");
        run_txn(1, 32'h13, 1'b0, 32'h0, "ld_misalign");
        run_txn(1, 32'h0, 1'b1, 32'hCAFE0000, "st_w0");
        run_txn(1, 32'h1000, 1'b0, 32'h0, "ld_oor");
        run_txn(1, 32'h1000, 1'b1, 32'hBAD0BAD0, "st_oor");
        run_txn(1, 32'h0, 1'b0, 32'h0, "ld_w0_after_oor");
        run_txn(1, 32'h10, 1'b0, 32'h0, "ld_w4_after_oor");

        // Flush/abort on LATENCY=2 and LATENCY=4
        for (int g = 1; g < NI; g++) begin
            run_txn(g, 32'h20, 1'b1, 32'h7777, "st_old20");
            run_txn(g, 32'h24, 1'b1, 32'h0, "st_old24");
            run_abort(g, 32'h20, 32'h24, 32'h1111, "abort");
            run_txn(g, 32'h20, 1'b0, 32'h0, "ld_20_after_abort");
            run_txn(g, 32'h24, 1'b0, 32'h0, "ld_24_after_abort");
        end

        // LATENCY=1 throughput with held inputs
        run_txn(0, 32'h0, 1'b1, 32'hAAAA0000, "l1_st0");
        run_txn(0, 32'h4, 1'b1, 32'hBBBB0004, "l1_st4");
        wait_idle(0);
        mem_addr[0] = 32'h4;
        mem_write[0] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (mem_valid[0] === 1'b1) begin
                pulses++;
                check_eq("l1_hold_data", mem_read_data[0], 32'hBBBB0004);
            end
        end
        check_eq("l1_pulses", 32'(pulses), 32'd4);
        for (int k = 0; k < 4; k++) begin
            run_txn(0, (k % 2 == 0) ? 32'h0 : 32'h4, 1'b0, 32'h0, "l1_alt");
        end

        // Reset in WAIT at cnt=1 on LATENCY=4 drops the pending store
        run_txn(2, 32'h8, 1'b1, 32'h0BADF00D, "st_prior8");
        wait_idle(2);
        mem_addr[2] = 32'h8;
        mem_write[2] = 1'b1;
        mem_write_data[2] = 32'hA5A5A5A5;
        @(negedge clk);
        check_eq("rstw_v1", 32'(mem_valid[2]), 32'd0);
        @(negedge clk);
        check_eq("rstw_v2", 32'(mem_valid[2]), 32'd0);
        rst_n[2] = 1'b0;
        mem_write[2] = 1'b0;
        @(negedge clk);
        rst_n[2] = 1'b1;
        check_eq("rstw_valid", 32'(mem_valid[2]), 32'd0);
        check_eq("rstw_err",   32'(mem_err[2]),   32'd0);
        check_eq("rstw_rdata", mem_read_data[2],  32'd0);
        check_eq("rstw_busy",  32'(busy[2]),      32'd0);
        run_txn(2, 32'h8, 1'b0, 32'h0, "ld_prior8");

        // Random traffic on every instance
        for (int g = 0; g < NI; g++) begin
            for (int i = 0; i < 40; i++) begin
                case ($urandom_range(0, 9))
                    0:       a = 32'h1000 + 32'($urandom_range(0, 255) << 2);
                    1:       a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    default: a = 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
                endcase
                w = 1'($urandom_range(0, 1));
                run_txn(g, a, w, $urandom, "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the data store; a power of 2.
REQ-002 Parameter LATENCY, default 2: cycles from request capture to mem_valid; legal range 1..7.
REQ-003 Port clk, input, 1: the single clock.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port mem_addr, input, 32: byte address from the CPU memory stage.
REQ-006 Port mem_write, input, 1: 1 = store, 0 = load.
REQ-007 Port mem_write_data, input, 32: store data.
REQ-008 Port mem_valid, output, 1: one-cycle response strobe.
REQ-009 Port mem_read_data, output, 32: load data, meaningful while mem_valid=1.
REQ-010 Port mem_err, output, 1: the address is out of range, qualified by mem_valid.
REQ-011 Port busy, output, 1: 1 while state is not IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-013 IDLE: on every edge, capture mem_addr, mem_write and mem_write_data into request registers; go to RESP if LATENCY=1, else go to WAIT with cnt=LATENCY-2.
REQ-014 WAIT: when cnt=0, go to RESP; otherwise decrement cnt.
REQ-015 RESP: mem_valid=1 for exactly this one cycle; the next state is IDLE unconditionally.
REQ-016 Timing: a request captured at edge t SHALL produce mem_valid high in the cycle after edge t+LATENCY-1 (LATENCY cycles of latency); back-to-back throughput is one response per LATENCY+1 cycles.
REQ-017 Abort: in WAIT, if mem_addr, mem_write or mem_write_data differs from the captured value (pipeline flush), recapture all three and reload cnt=LATENCY-2, or go to RESP if LATENCY=1; no store is performed for the aborted request.
REQ-018 Index: word index = captured addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] is ignored (word access only).
REQ-019 Range check: out_of_range is true when captured addr >= 4*DEPTH_WORDS.
REQ-020 Store: performed on the edge entering RESP, only if captured write=1 and out_of_range=0.
REQ-021 Load: mem_read_data is registered on the edge entering RESP from the store contents, or 32'h0 if out_of_range.
REQ-022 Store response: mem_read_data SHALL be 32'h0 during a store response.
REQ-023 Error flag: mem_err is registered with the response and equals out_of_range; it is 0 when mem_valid=0.
REQ-024 Hold values: mem_read_data holds its value outside RESP; mem_valid is 0 outside RESP.
REQ-025 Ordering: a load following a store to the same word SHALL return the stored data (the store commits before any later capture).

Reset
REQ-026 While rst_n=0 at an edge: state=IDLE, cnt=0, mem_valid=0, mem_read_data=0, mem_err=0, busy=0, request registers=0.
REQ-027 Reset in WAIT or on the edge that would enter RESP SHALL drop the pending store; the store array contents are not reset.
REQ-028 First capture after release: the first request capture occurs on the first edge with rst_n=1.

Structure
REQ-029 Shared package/header riscv_mem_pkg SHALL hold the state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), the LATENCY counter width (3) and the word size.
REQ-030 The store SHALL be sub-module dmem_array: single-port, synchronous read and write, DEPTH_WORDS x 32, with no reset.
REQ-031 The FSM, counter, request registers and range check live in dmem_responder.

Verification
REQ-032 LATENCY=2, store 32'hDEADBEEF to 0x10, then load 0x10 -> mem_valid 2 cycles after each capture; the load returns 32'hDEADBEEF with mem_err=0.
REQ-033 LATENCY=1, alternate loads from 0x0 and 0x4 with the inputs held across responses -> mem_valid pulses every 2nd cycle, never two consecutive cycles high.
REQ-034 Abort: store 0x20 <- 32'h1111 started, then the address changes to 0x24 one cycle later -> response arrives LATENCY cycles after the change; a subsequent load of 0x20 returns the old contents and 0x24 holds 32'h1111.
REQ-035 Out of range: load of 0x1000 with DEPTH_WORDS=1024 -> mem_valid=1, mem_err=1, mem_read_data=0; a store to 0x1000 leaves all words unchanged.
REQ-036 Reset mid-WAIT: LATENCY=4 store 32'hA5A5A5A5 to 0x8, rst_n low for 1 cycle at cnt=1 -> no mem_valid, all outputs 0; a later load of 0x8 returns the prior value.
REQ-037 Misaligned: load 0x13 after a store of 32'h12345678 to 0x10 -> returns 32'h12345678.
